// File: rtl/change_dispenser_if.sv
// Request/stock/payout signal bundle between the vending controller and the
// coin-payout unit.
interface change_dispenser_if #(
   parameter int AMT_W = 4,
   parameter int CNT_W = 4
);
   logic             start;
   logic [AMT_W-1:0] amount;
   logic             refill;
   logic [CNT_W-1:0] refill_five;
   logic [CNT_W-1:0] refill_two;
   logic [CNT_W-1:0] refill_one;
   logic             busy;
   logic             pay_five;
   logic             pay_two;
   logic             pay_one;
   logic             done;
   logic             short;
   logic [AMT_W-1:0] rem_amt;
   logic [CNT_W-1:0] stock_five;
   logic [CNT_W-1:0] stock_two;
   logic [CNT_W-1:0] stock_one;

   modport master (
      output start, amount, refill, refill_five, refill_two, refill_one,
      input  busy, pay_five, pay_two, pay_one, done, short, rem_amt,
             stock_five, stock_two, stock_one
   );

   modport slave (
      input  start, amount, refill, refill_five, refill_two, refill_one,
      output busy, pay_five, pay_two, pay_one, done, short, rem_amt,
             stock_five, stock_two, stock_one
   );
endinterface

// File: rtl/change_dispenser.sv
// Coin-payout unit: pays a requested amount as single-cycle 5/2/1 coin
// pulses, greedy selection against a finite per-denomination stock.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start / refill
// S_SELECT | pick the next coin, or decide completion (short or not)
// S_PULSE  | one-cycle eject pulse; amount and stock decrement
// S_GAP    | PULSE_GAP idle cycles between pulses
// S_FINISH | one-cycle done pulse
module change_dispenser #(
   parameter int AMT_W      = 4,
   parameter int CNT_W      = 4,
   parameter int INIT_STOCK = 4,
   parameter int PULSE_GAP  = 1
) (
   input  logic                clk,
   input  logic                reset,
   change_dispenser_if.slave   bus
);
   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_FINISH} state_t;
   typedef enum logic [1:0] {C_NONE, C_FIVE, C_TWO, C_ONE} coin_t;

   localparam int GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = (PULSE_GAP > 0) ? GAP_W'(PULSE_GAP - 1) : '0;

   state_t           state, next_state;
   coin_t            coin, coin_sel;
   logic             short_set;
   logic             short_r;
   logic [AMT_W-1:0] rem_amt;
   logic [AMT_W-1:0] coin_val;
   logic [CNT_W-1:0] stock_five, stock_two, stock_one;
   logic [GAP_W-1:0] gap_cnt;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= next_state;
   end

   // Next-state logic and greedy coin selection
   always_comb begin
      next_state = state;
      coin_sel   = C_NONE;
      short_set  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) next_state = S_SELECT;
         end
         S_SELECT: begin
            if (rem_amt >= AMT_W'(5) && stock_five != '0) begin
               coin_sel   = C_FIVE;
               next_state = S_PULSE;
            end else if (rem_amt >= AMT_W'(2) && stock_two != '0) begin
               coin_sel   = C_TWO;
               next_state = S_PULSE;
            end else if (rem_amt >= AMT_W'(1) && stock_one != '0) begin
               coin_sel   = C_ONE;
               next_state = S_PULSE;
            end else begin
               short_set  = (rem_amt != '0);
               next_state = S_FINISH;
            end
         end
         S_PULSE: begin
            next_state = (PULSE_GAP == 0) ? S_SELECT : S_GAP;
         end
         S_GAP: begin
            if (gap_cnt == '0) next_state = S_SELECT;
         end
         S_FINISH: begin
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Value of the coin currently being ejected
   always_comb begin
      coin_val = '0;
      case (coin)
         C_FIVE:  coin_val = AMT_W'(5);
         C_TWO:   coin_val = AMT_W'(2);
         C_ONE:   coin_val = AMT_W'(1);
         default: coin_val = '0;
      endcase
   end

   // Amount, stock, shortfall flag and gap timer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         coin       <= C_NONE;
         rem_amt    <= '0;
         short_r    <= 1'b0;
         gap_cnt    <= '0;
         stock_five <= CNT_W'(INIT_STOCK);
         stock_two  <= CNT_W'(INIT_STOCK);
         stock_one  <= CNT_W'(INIT_STOCK);
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.refill) begin
                  stock_five <= bus.refill_five;
                  stock_two  <= bus.refill_two;
                  stock_one  <= bus.refill_one;
               end
               if (bus.start) begin
                  rem_amt <= bus.amount;
                  short_r <= 1'b0;
               end
            end
            S_SELECT: begin
               coin <= coin_sel;
               if (short_set) short_r <= 1'b1;
            end
            S_PULSE: begin
               rem_amt <= rem_amt - coin_val;
               gap_cnt <= GAP_LOAD;
               case (coin)
                  C_FIVE:  stock_five <= stock_five - CNT_W'(1);
                  C_TWO:   stock_two  <= stock_two  - CNT_W'(1);
                  C_ONE:   stock_one  <= stock_one  - CNT_W'(1);
                  default: ;
               endcase
            end
            S_GAP: begin
               if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = (state != S_IDLE);
   assign bus.pay_five   = (state == S_PULSE) && (coin == C_FIVE);
   assign bus.pay_two    = (state == S_PULSE) && (coin == C_TWO);
   assign bus.pay_one    = (state == S_PULSE) && (coin == C_ONE);
   assign bus.done       = (state == S_FINISH);
   assign bus.short      = short_r;
   assign bus.rem_amt    = rem_amt;
   assign bus.stock_five = stock_five;
   assign bus.stock_two  = stock_two;
   assign bus.stock_one  = stock_one;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: one instance with PULSE_GAP=1, one with 0.
module tb_change_dispenser;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   change_dispenser_if #(.AMT_W(4), .CNT_W(4)) bus1 ();
   change_dispenser_if #(.AMT_W(4), .CNT_W(4)) bus0 ();

   change_dispenser #(.AMT_W(4), .CNT_W(4), .INIT_STOCK(4), .PULSE_GAP(1)) dut (
      .clk(clk), .reset(reset), .bus(bus1));
   change_dispenser #(.AMT_W(4), .CNT_W(4), .INIT_STOCK(4), .PULSE_GAP(0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0));

   logic       start = 1'b0, refill = 1'b0, use0 = 1'b0;
   logic [3:0] amount = '0, rf5 = '0, rf2 = '0, rf1 = '0;

   assign bus1.start = start & ~use0;
   assign bus1.refill = refill & ~use0;
   assign bus1.amount = amount;
   assign bus1.refill_five = rf5;
   assign bus1.refill_two = rf2;
   assign bus1.refill_one = rf1;
   assign bus0.start = start & use0;
   assign bus0.refill = refill & use0;
   assign bus0.amount = amount;
   assign bus0.refill_five = rf5;
   assign bus0.refill_two = rf2;
   assign bus0.refill_one = rf1;

   logic       o_busy, o_p5, o_p2, o_p1, o_done, o_short;
   logic [3:0] o_rem, o_s5, o_s2, o_s1;
   assign o_busy  = use0 ? bus0.busy : bus1.busy;
   assign o_p5    = use0 ? bus0.pay_five : bus1.pay_five;
   assign o_p2    = use0 ? bus0.pay_two : bus1.pay_two;
   assign o_p1    = use0 ? bus0.pay_one : bus1.pay_one;
   assign o_done  = use0 ? bus0.done : bus1.done;
   assign o_short = use0 ? bus0.short : bus1.short;
   assign o_rem   = use0 ? bus0.rem_amt : bus1.rem_amt;
   assign o_s5    = use0 ? bus0.stock_five : bus1.stock_five;
   assign o_s2    = use0 ? bus0.stock_two : bus1.stock_two;
   assign o_s1    = use0 ? bus0.stock_one : bus1.stock_one;

   int total = 0;
   int bad = 0;
   int m_s5 = 4, m_s2 = 4, m_s1 = 4;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      m_s5 = 4; m_s2 = 4; m_s1 = 4;
   endtask

   // Issue one request at the current negedge (DUT idle) and check every
   // cycle up to and including the first IDLE cycle against a timeline
   // worked out from the payout rules.
   task automatic do_req(input int amt, input bit rf, input int r5, input int r2,
                         input int r1, input int gap, input bit inj,
                         output int done_obs);
      int pay[64];
      int rem, t, coin, done_c, sh, act, exp;
      for (int i = 0; i < 64; i++) pay[i] = 0;
      if (rf) begin m_s5 = r5; m_s2 = r2; m_s1 = r1; end
      rem = amt;
      t = 1;
      for (int k = 0; k < 20; k++) begin
         coin = 0;
         if (rem >= 5 && m_s5 > 0) begin coin = 5; m_s5--; end
         else if (rem >= 2 && m_s2 > 0) begin coin = 2; m_s2--; end
         else if (rem >= 1 && m_s1 > 0) begin coin = 1; m_s1--; end
         if (coin == 0) break;
         pay[t + 1] = coin;
         rem -= coin;
         t += 2 + gap;
      end
      done_c = t + 1;
      sh = (rem != 0) ? 1 : 0;

      start = 1'b1; amount = 4'(amt); refill = rf;
      rf5 = 4'(r5); rf2 = 4'(r2); rf1 = 4'(r1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; refill = 1'b0;
      done_obs = -1;
      for (int c = 1; c <= done_c + 1; c++) begin
         if (inj && c == 3) begin
            start = 1'b1; refill = 1'b1; amount = 4'd1;
            rf5 = 4'd0; rf2 = 4'd0; rf1 = 4'd0;
         end else if (inj && c == 5) begin
            start = 1'b0; refill = 1'b0;
         end
         exp = {27'd0, c <= done_c, pay[c] == 5, pay[c] == 2, pay[c] == 1, c == done_c};
         act = {27'd0, o_busy, o_p5, o_p2, o_p1, o_done};
         if (o_done && done_obs < 0) done_obs = c;
         chk($sformatf("amt%0d cyc%0d busy/p5/p2/p1/done", amt, c), act, exp);
         if (c == done_c) begin
            chk($sformatf("amt%0d short", amt), int'(o_short), sh);
            chk($sformatf("amt%0d rem_amt", amt), int'(o_rem), rem);
         end
         if (c == done_c + 1) begin
            chk($sformatf("amt%0d short hold", amt), int'(o_short), sh);
            chk($sformatf("amt%0d stock_five", amt), int'(o_s5), m_s5);
            chk($sformatf("amt%0d stock_two", amt), int'(o_s2), m_s2);
            chk($sformatf("amt%0d stock_one", amt), int'(o_s1), m_s1);
         end
         if (c <= done_c) @(negedge clk);
      end
   endtask

   typedef struct {
      int amt; bit rf; int r5; int r2; int r1;
      int done_c; int sh; int rem; int s5; int s2; int s1;
   } vec_t;
   vec_t vecs[8];

   initial begin
      int dobs;
      int r5, r2, r1;
      bit rf;
      vecs[0] = '{8,  1'b0, 0, 0, 0,     11, 0, 0, 3, 3, 3};
      vecs[1] = '{0,  1'b0, 0, 0, 0,      2, 0, 0, 3, 3, 3};
      vecs[2] = '{7,  1'b1, 0, 1, 0,      5, 1, 5, 0, 0, 0};
      vecs[3] = '{6,  1'b1, 1, 5, 0,      5, 1, 1, 0, 5, 0};
      vecs[4] = '{15, 1'b1, 2, 2, 2,     17, 0, 0, 0, 0, 1};
      vecs[5] = '{3,  1'b0, 0, 0, 0,      5, 1, 2, 0, 0, 0};
      vecs[6] = '{14, 1'b1, 15, 15, 15,  14, 0, 0, 13, 13, 15};
      vecs[7] = '{0,  1'b0, 0, 0, 0,      2, 0, 0, 13, 13, 15};

      // reset state
      repeat (2) @(negedge clk);
      chk("reset flags", {o_busy, o_p5, o_p2, o_p1, o_done, o_short}, 0);
      chk("reset rem", int'(o_rem), 0);
      chk("reset stocks", {o_s5, o_s2, o_s1}, 12'h444);
      reset = 1'b1;
      @(negedge clk);

      // table vectors, PULSE_GAP=1, stock carries from one to the next
      for (int i = 0; i < 8; i++) begin
         do_req(vecs[i].amt, vecs[i].rf, vecs[i].r5, vecs[i].r2, vecs[i].r1, 1, 1'b0, dobs);
         chk($sformatf("vec%0d done cycle", i), dobs, vecs[i].done_c);
         chk($sformatf("vec%0d short", i), int'(o_short), vecs[i].sh);
         chk($sformatf("vec%0d rem", i), int'(o_rem), vecs[i].rem);
         chk($sformatf("vec%0d stocks", i), {o_s5, o_s2, o_s1},
             (vecs[i].s5 << 8) | (vecs[i].s2 << 4) | vecs[i].s1);
      end

      // start/refill strobes during a payout are ignored
      do_req(9, 1'b1, 4, 4, 4, 1, 1'b1, dobs);
      chk("inject done cycle", dobs, 11);
      chk("inject stocks", {o_s5, o_s2, o_s1}, 12'h324);

      // reset in the middle of a 15-unit payout
      start = 1'b1; amount = 4'd15;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midreset flags", {o_busy, o_p5, o_p2, o_p1, o_done, o_short}, 0);
      chk("midreset rem", int'(o_rem), 0);
      chk("midreset stocks", {o_s5, o_s2, o_s1}, 12'h444);
      @(negedge clk);
      reset = 1'b1;
      m_s5 = 4; m_s2 = 4; m_s1 = 4;
      @(negedge clk);
      chk("no resume busy", int'(o_busy), 0);
      do_req(8, 1'b0, 0, 0, 0, 1, 1'b0, dobs);
      chk("post-reset done cycle", dobs, 11);
      chk("post-reset stocks", {o_s5, o_s2, o_s1}, 12'h333);

      // random requests, PULSE_GAP=1
      for (int i = 0; i < 30; i++) begin
         rf = ($urandom_range(0, 1) == 1);
         r5 = $urandom_range(0, 15); r2 = $urandom_range(0, 15); r1 = $urandom_range(0, 15);
         do_req($urandom_range(0, 15), rf, r5, r2, r1, 1, 1'b0, dobs);
      end

      // PULSE_GAP=0 instance
      use0 = 1'b1;
      do_reset();
      do_req(4, 1'b0, 0, 0, 0, 0, 1'b0, dobs);
      chk("gap0 amt4 done cycle", dobs, 6);
      for (int i = 0; i < 20; i++) begin
         rf = ($urandom_range(0, 1) == 1);
         r5 = $urandom_range(0, 15); r2 = $urandom_range(0, 15); r1 = $urandom_range(0, 15);
         do_req($urandom_range(0, 15), rf, r5, r2, r1, 0, 1'b0, dobs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-payout unit on the output side of the vending-machine controller: accepts a change request (amount in units) and pays it out as a sequence of single-cycle coin pulses on `pay_five`, `pay_two` and `pay_one`, using the same 1/2/5 coin denominations the controller accepts. Tracks a finite per-denomination coin stock, selects coins greedily, and flags a shortfall when stock cannot cover the request. Sits between the vending-machine FSM's change output and the coin-ejector solenoid drivers.

## Interface

- `AMT_W`, 4, width of requested amount and remaining-amount counter
- `CNT_W`, 4, width of each coin-stock counter
- `INIT_STOCK`, 4, stock loaded into all three counters on reset
- `PULSE_GAP`, 1, idle cycles between consecutive coin pulses; 0 is legal

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request strobe, sampled only in IDLE
- `amount`  in  AMT_W  change to pay, captured with `start`
- `refill`  in  1  stock load strobe, sampled only in IDLE
- `refill_five`, `refill_two`, `refill_one`  in  CNT_W each  new stock values loaded on `refill`
- `busy`  out  1  high whenever state is not IDLE
- `pay_five`, `pay_two`, `pay_one`  out  1 each  one-cycle coin eject pulses, mutually exclusive
- `done`  out  1  one-cycle pulse when a request completes
- `short`  out  1  valid with `done`; 1 = stock could not cover the request; holds until next `start` is accepted
- `rem_amt`  out  AMT_W  remaining unpaid amount; after completion, the undispensed shortfall
- `stock_five`, `stock_two`, `stock_one`  out  CNT_W each  current coin stock

## Operation

- States: IDLE, SELECT, PULSE, GAP, FINISH. All outputs are registered/Moore; none depend combinationally on inputs.
- IDLE: `start`=1 -> capture `amount` into `rem_amt`, clear `short`, go to SELECT. `start` outside IDLE is ignored.
- IDLE: `refill`=1 -> load all three stock counters from `refill_*`. `refill` outside IDLE is ignored. `refill` and `start` in the same IDLE cycle: both take effect; SELECT uses the refilled stock.
- SELECT, checked in priority order:
  - `rem_amt`>=5 and `stock_five`>0 -> coin=five
  - else `rem_amt`>=2 and `stock_two`>0 -> coin=two
  - else `rem_amt`>=1 and `stock_one`>0 -> coin=one
  - else `rem_amt`==0 -> FINISH with `short`=0
  - else -> FINISH with `short`=1
- Selection is greedy and non-backtracking; short results this causes are accepted behaviour. Example: 6 with no ones and ample twos pays 5 and then reports short, rather than paying 2+2+2.
- PULSE: the selected `pay_*` is high for exactly one cycle. On the same edge, `rem_amt` drops by the coin value and that stock counter drops by 1. Neither can underflow, because SELECT checks both first.
- GAP: stays PULSE_GAP cycles, then returns to SELECT. With PULSE_GAP=0, PULSE goes directly to SELECT.
- FINISH: `done`=1 for one cycle, then IDLE.
- Reset (asserted at any time, including mid-payout): state IDLE; `busy`, `pay_*`, `done` and `short` all 0; `rem_amt`=0; all stock counters = INIT_STOCK. An aborted payout is not resumed.

## Timing

- Edge 0 accepts `start`. Cycle 1: SELECT, `busy`=1. Cycle 2: first coin pulse.
- Each coin costs 2+PULSE_GAP cycles (SELECT, PULSE, GAP). Completion adds SELECT + FINISH.
- `amount`=0: SELECT in cycle 1, `done` in cycle 2, IDLE in cycle 3.
- `busy` is high from the cycle after `start` through the FINISH cycle. A new `start` is accepted in the first IDLE cycle.
- At most one `pay_*` is high in any cycle. Two coin pulses are never adjacent when PULSE_GAP>=1.

## Test plan

- Reset; `amount`=8; PULSE_GAP=1 -> pulses `pay_five` in cycle 2, `pay_two` in cycle 5, `pay_one` in cycle 8; `done` in cycle 11 with `short`=0; stocks end at 3/3/3.
- `amount`=0 -> no pulses; `done` in cycle 2; `short`=0; `busy` high in cycles 1-2 only.
- Refill five=0, two=1, one=0; `amount`=7 -> one `pay_two`; `done` with `short`=1 and `rem_amt`=5; `stock_two`=0.
- `start` and `refill` pulsed during a payout -> both ignored; payout and stock values unaffected. `start` and `refill` in the same IDLE cycle -> new stock is used for the payout.
- `reset` driven low in the middle of a 15-unit payout -> all outputs clear immediately, stocks return to 4/4/4; the next `start` behaves as it does from a fresh reset.
- PULSE_GAP=0 with `amount`=4 -> `pay_two` in cycles 2 and 4; `done` in cycle 6.
